// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  localparam int WORD_W_DEF = 64;
  localparam int TAG_W      = 4;
  localparam int TO_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_e;

  // A single requester still needs a one-bit grant index.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set request at or after ptr
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int GID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             found,
  output logic [GID_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // Rotate so bit 0 of rot is the requester the pointer names.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    int sum;
    sum   = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        idx   = GID_W'(sum);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N word producers
// Optional: define UART_ARB_TAG_EN to stamp the grant index into the top 4 bits of tx_reg.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  N_REQ        = 4,
  parameter int  WORD_W       = WORD_W_DEF,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int GID_W        = gid_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic [WORD_W-1:0]       tx_reg,
  output logic                    tx_en,
  input  logic                    tx_busy,
  output logic [GID_W-1:0]        grant_id,
  output logic [TO_CNT_W-1:0]     timeout_cnt
);

  localparam int WAIT_W = ($clog2(BUSY_TIMEOUT) > 0) ? $clog2(BUSY_TIMEOUT) : 1;

  arb_state_e        state;
  logic [GID_W-1:0]  ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pick_found;
  logic [GID_W-1:0]  pick_idx;
  logic [WORD_W-1:0] sel_word;
  logic [WORD_W-1:0] latch_word;

  rr_picker #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_word = req_data[grant_id*WORD_W +: WORD_W];

`ifdef UART_ARB_TAG_EN
  assign latch_word = {TAG_W'(grant_id), sel_word[WORD_W-TAG_W-1:0]};
`else
  assign latch_word = sel_word;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tx_en       <= 1'b0;
      req_ack     <= '0;
      tx_reg      <= '0;
      grant_id    <= '0;
      timeout_cnt <= '0;
      ptr         <= '0;
      wait_cnt    <= '0;
    end else begin
      tx_en   <= 1'b0;
      req_ack <= '0;
      case (state)
        // A busy UART here means a frame survived our reset; let it drain first.
        ST_IDLE: begin
          if (pick_found && !tx_busy) begin
            grant_id <= pick_idx;
            state    <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          tx_reg            <= latch_word;
          req_ack[grant_id] <= 1'b1;
          ptr               <= (grant_id == GID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state             <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          tx_en    <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == WAIT_W'(BUSY_TIMEOUT - 1)) begin
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
